// File: rtl/jam_pkg.sv
// jam_pkg: shared constants and types for the permutation sequencer.
//   N    - number of workers / jobs
//   IDXW - job index width (clog2(N))
//   CNTW - width of the accepted-permutation counter (holds N!)
//   state_t - sequencer FSM states
//   perm_t  - one job index per worker, worker k at element k
package jam_pkg;
    localparam int N    = 8;
    localparam int IDXW = 3;
    localparam int CNTW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_PIVOT,
        S_SUCC,
        S_SWAP,
        S_REV,
        S_DONE
    } state_t;

    typedef logic [N-1:0][IDXW-1:0] perm_t;
endpackage

// File: rtl/jam_suffix_reverse.sv
// jam_suffix_reverse: combinational reversal of the permutation suffix
// that follows the pivot.
//   i_perm - permutation, element k = job of worker k
//   i_piv  - pivot index; elements i_piv+1 .. N-1 are reversed
//   o_perm - permutation with that suffix reversed, prefix unchanged
module jam_suffix_reverse #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0][IDXW-1:0] i_perm,
    input  logic [IDXW-1:0]        i_piv,
    output logic [N-1:0][IDXW-1:0] o_perm
);
    logic [IDXW-1:0] w_src;

    always_comb begin
        w_src  = '0;
        o_perm = i_perm;
        for (int k = 0; k < N; k++) begin
            // Position k in the suffix mirrors position (N-1) - (k-(piv+1)).
            if (k > int'(i_piv)) begin
                w_src     = IDXW'(N + int'(i_piv) - k);
                o_perm[k] = i_perm[w_src];
            end
        end
    end
endmodule

// File: rtl/jam_perm_sequencer.sv
// jam_perm_sequencer: enumerates all N! job-to-worker assignments in
// increasing lexicographic order (identity first, descending last) and
// offers each one downstream over valid/ready.
//   CLK, RST             - clock, synchronous active-high reset
//   start                - begin a full enumeration (from IDLE or DONE)
//   abort                - return to IDLE with reset values, any state
//   perm                 - current permutation, worker k at [k*IDXW +: IDXW]
//   perm_valid/ready     - downstream handshake
//   perm_last            - offered perm is the final (descending) one
//   perm_count           - permutations accepted so far
//   busy                 - enumeration in progress (not IDLE/DONE)
//   done                 - enumeration complete
module jam_perm_sequencer #(
    parameter int N    = jam_pkg::N,
    parameter int IDXW = jam_pkg::IDXW,
    parameter int CNTW = jam_pkg::CNTW
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                abort,
    output logic [N*IDXW-1:0]   perm,
    output logic                perm_valid,
    input  logic                perm_ready,
    output logic                perm_last,
    output logic [CNTW-1:0]     perm_count,
    output logic                busy,
    output logic                done
);
    import jam_pkg::*;

    typedef logic [N-1:0][IDXW-1:0] lperm_t;

    function automatic lperm_t identity();
        lperm_t f;
        for (int k = 0; k < N; k++) f[k] = IDXW'(k);
        return f;
    endfunction

    state_t          r_state, w_state_nxt;
    lperm_t          r_perm, w_perm_nxt, w_rev;
    logic [IDXW-1:0] r_i, w_i_nxt;
    logic [IDXW-1:0] r_j, w_j_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic            r_valid, r_busy, r_done;
    logic            w_desc;

    jam_suffix_reverse #(.N(N), .IDXW(IDXW)) u_rev (
        .i_perm (r_perm),
        .i_piv  (r_i),
        .o_perm (w_rev)
    );

    always_comb begin
        w_desc = 1'b1;
        for (int k = 0; k < N; k++)
            if (r_perm[k] != IDXW'(N - 1 - k)) w_desc = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_perm_nxt  = r_perm;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_perm_nxt  = identity();
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (perm_ready) begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                    if (w_desc) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt     = IDXW'(N - 2);
                        w_state_nxt = S_PIVOT;
                    end
                end
            end
            S_PIVOT: begin
                // Never underflows: the descending perm exits from EMIT.
                if (r_perm[r_i] < r_perm[r_i + 1'b1]) begin
                    w_j_nxt     = IDXW'(N - 1);
                    w_state_nxt = S_SUCC;
                end else begin
                    w_i_nxt = r_i - 1'b1;
                end
            end
            S_SUCC: begin
                if (r_perm[r_j] > r_perm[r_i]) w_state_nxt = S_SWAP;
                else                           w_j_nxt     = r_j - 1'b1;
            end
            S_SWAP: begin
                w_perm_nxt[r_i] = r_perm[r_j];
                w_perm_nxt[r_j] = r_perm[r_i];
                w_state_nxt     = S_REV;
            end
            S_REV: begin
                w_perm_nxt  = w_rev;
                w_state_nxt = S_EMIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // abort outranks everything, including a simultaneous start.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_perm_nxt  = identity();
            w_i_nxt     = '0;
            w_j_nxt     = '0;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_perm  <= identity();
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_perm  <= w_perm_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_cnt   <= w_cnt_nxt;
            // Status flags are decoded from the next state so they are registered.
            r_valid <= (w_state_nxt == S_EMIT);
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign perm       = r_perm;
    assign perm_valid = r_valid;
    assign perm_last  = r_valid & w_desc;
    assign perm_count = r_cnt;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_jam_perm_sequencer.sv
// Scoreboarded bench. The N=8 instance covers reset, timing, stall,
// start-in-PIVOT and abort-in-SUCC; a full enumeration at N=8 is far too
// long, so a second instance with N=5 (120 perms) runs the complete
// sequence with random back-pressure and a restart from DONE.
module tb_jam_perm_sequencer;
    typedef logic [7:0][3:0] pa_t;
    typedef struct { pa_t p; logic last; } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        start8 = 0, abort8 = 0, ready8 = 0;
    logic [23:0] perm8;
    logic        valid8, last8, busy8, done8;
    logic [15:0] cnt8;

    logic        start5 = 0, abort5 = 0, ready5 = 0;
    logic [14:0] perm5;
    logic        valid5, last5, busy5, done5;
    logic [7:0]  cnt5;

    jam_perm_sequencer #(.N(8), .IDXW(3), .CNTW(16)) dut8 (
        .CLK(CLK), .RST(RST), .start(start8), .abort(abort8),
        .perm(perm8), .perm_valid(valid8), .perm_ready(ready8),
        .perm_last(last8), .perm_count(cnt8), .busy(busy8), .done(done8)
    );

    jam_perm_sequencer #(.N(5), .IDXW(3), .CNTW(8)) dut5 (
        .CLK(CLK), .RST(RST), .start(start5), .abort(abort5),
        .perm(perm5), .perm_valid(valid5), .perm_ready(ready5),
        .perm_last(last5), .perm_count(cnt5), .busy(busy5), .done(done5)
    );

    int   checks = 0, errors = 0;
    int   hs8 = 0, hs5 = 0;
    exp_t q8[$], q5[$];
    exp_t e8, e5;
    pa_t  last_p8, prev5;
    logic have_prev5 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input pa_t p, input int n);
        logic [31:0] o = '0;
        for (int k = 0; k < n; k++) o[3*k +: 3] = p[k][2:0];
        return o;
    endfunction

    function automatic pa_t unpk5(input logic [14:0] f);
        pa_t p = '0;
        for (int k = 0; k < 5; k++) p[k] = {1'b0, f[3*k +: 3]};
        return p;
    endfunction

    function automatic pa_t from8(input int v[8]);
        pa_t p = '0;
        for (int k = 0; k < 8; k++) p[k] = 4'(v[k]);
        return p;
    endfunction

    function automatic pa_t ident(input int n);
        pa_t p = '0;
        for (int k = 0; k < n; k++) p[k] = 4'(k);
        return p;
    endfunction

    function automatic logic is_desc(input pa_t p, input int n);
        for (int k = 0; k < n; k++) if (p[k] != 4'(n - 1 - k)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pivot(input pa_t p, input int n);
        int i = n - 2;
        while (i >= 0 && p[i] >= p[i+1]) i--;
        return i;
    endfunction

    // Textbook lexicographic successor.
    function automatic pa_t next_p(input pa_t p, input int n);
        pa_t r = p;
        logic [3:0] t;
        int i, j, a, b;
        i = pivot(p, n);
        if (i < 0) return r;
        j = n - 1;
        while (r[j] <= r[i]) j--;
        t = r[i]; r[i] = r[j]; r[j] = t;
        a = i + 1; b = n - 1;
        while (a < b) begin
            t = r[a]; r[a] = r[b]; r[b] = t;
            a++; b--;
        end
        return r;
    endfunction

    function automatic logic lex_gt(input pa_t a, input pa_t b, input int n);
        for (int k = 0; k < n; k++) begin
            if (a[k] > b[k]) return 1'b1;
            if (a[k] < b[k]) return 1'b0;
        end
        return 1'b0;
    endfunction

    // Monitors: pop one expectation per accepted handshake.
    always @(negedge CLK) begin
        if (valid8 && ready8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL hs8_unexpected: got perm %0h expected no handshake", perm8);
            end else begin
                e8 = q8.pop_front();
                chk("perm8", 32'(perm8), pk(e8.p, 8));
                chk("last8", 32'(last8), 32'(e8.last));
                last_p8 = e8.p;
            end
            hs8++;
        end
    end

    always @(negedge CLK) begin
        if (valid5 && ready5) begin
            if (q5.size() == 0) begin
                checks++; errors++;
                $display("FAIL hs5_unexpected: got perm %0h expected no handshake", perm5);
            end else begin
                e5 = q5.pop_front();
                chk("perm5", 32'(perm5), pk(e5.p, 5));
                chk("last5", 32'(last5), 32'(e5.last));
            end
            if (have_prev5) chk("lex_inc5", 32'(lex_gt(unpk5(perm5), prev5, 5)), 1);
            prev5      = unpk5(perm5);
            have_prev5 = !last5;
            hs5++;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Returns just after the negedge on which the target handshake is seen.
    task automatic wait_hs(input bit sel5, input int tgt);
        int n = 0;
        while ((sel5 ? hs5 : hs8) < tgt && n < 3000) begin
            @(negedge CLK); #1; n++;
        end
        chk(sel5 ? "hs5_timeout" : "hs8_timeout", 32'((sel5 ? hs5 : hs8) >= tgt), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v2[8] = '{0,1,2,3,4,5,7,6};
        int   v3[8] = '{0,1,2,3,4,6,5,7};
        pa_t  p;
        int   k, piv, n;

        // Reset with start held: start must be ignored.
        start8 = 1; start5 = 1;
        repeat (3) tick();
        RST = 0; start8 = 0; start5 = 0;
        repeat (5) tick();
        chk("rst_perm8",  32'(perm8),  pk(ident(8), 8));
        chk("rst_valid8", 32'(valid8), 0);
        chk("rst_last8",  32'(last8),  0);
        chk("rst_busy8",  32'(busy8),  0);
        chk("rst_done8",  32'(done8),  0);
        chk("rst_cnt8",   32'(cnt8),   0);
        chk("rst_perm5",  32'(perm5),  pk(ident(5), 5));
        chk("rst_valid5", 32'(valid5), 0);

        // First three perms, ready high, then a 10-cycle stall on the third.
        q8.push_back('{ident(8), 1'b0});
        q8.push_back('{from8(v2), 1'b0});
        q8.push_back('{from8(v3), 1'b0});
        ready8 = 1; start8 = 1;
        tick();
        start8 = 0;
        @(negedge CLK); #1;
        chk("start_latency", 32'(valid8), 1);
        chk("busy_emit", 32'(busy8), 1);
        k = 0;
        do begin @(negedge CLK); #1; k++; end while (!valid8 && k < 20);
        chk("gap_idle_cycles", 32'(k - 1), 4);
        wait_hs(0, 2);
        tick();
        ready8 = 0;
        k = 0;
        while (!valid8 && k < 20) begin @(negedge CLK); #1; k++; end
        for (int c = 0; c < 10; c++) begin
            chk("stall_perm",  32'(perm8),  pk(from8(v3), 8));
            chk("stall_valid", 32'(valid8), 1);
            chk("stall_cnt",   32'(cnt8),   2);
            @(negedge CLK); #1;
        end
        tick();
        ready8 = 1;
        wait_hs(0, 3);
        tick();
        chk("cnt_after_stall", 32'(cnt8), 3);
        ready8 = 0; abort8 = 1;
        tick();
        abort8 = 0;
        chk("abort1_valid", 32'(valid8), 0);
        chk("abort1_cnt",   32'(cnt8),   0);

        // 100 perms, start pulsed in PIVOT, then abort (with start) in SUCC.
        p = ident(8);
        for (int i = 0; i < 100; i++) begin
            q8.push_back('{p, is_desc(p, 8)});
            p = next_p(p, 8);
        end
        ready8 = 1; start8 = 1;
        tick();
        start8 = 0;
        wait_hs(0, 53);
        tick();
        start8 = 1;
        tick();
        start8 = 0;
        wait_hs(0, 103);
        tick();
        ready8 = 0;
        piv = pivot(last_p8, 8);
        repeat (8 - 1 - piv) tick();
        chk("busy_succ", 32'(busy8), 1);
        abort8 = 1; start8 = 1;
        tick();
        abort8 = 0; start8 = 0;
        chk("abort_perm",  32'(perm8),  pk(ident(8), 8));
        chk("abort_valid", 32'(valid8), 0);
        chk("abort_last",  32'(last8),  0);
        chk("abort_busy",  32'(busy8),  0);
        chk("abort_done",  32'(done8),  0);
        chk("abort_cnt",   32'(cnt8),   0);
        repeat (3) tick();
        chk("abort_wins_start", 32'(valid8), 0);
        q8.push_back('{ident(8), 1'b0});
        ready8 = 1; start8 = 1;
        tick();
        start8 = 0;
        wait_hs(0, 104);
        tick();
        ready8 = 0; abort8 = 1;
        tick();
        abort8 = 0;

        // Full N=5 enumeration with random back-pressure.
        p = ident(5);
        for (int i = 0; i < 120; i++) begin
            q5.push_back('{p, is_desc(p, 5)});
            p = next_p(p, 5);
        end
        start5 = 1;
        tick();
        start5 = 0;
        n = 0;
        while (hs5 < 120 && n < 5000) begin
            ready5 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("full_hs_count", 32'(hs5), 120);
        chk("full_done",  32'(done5),  1);
        chk("full_cnt",   32'(cnt5),   120);
        chk("full_busy",  32'(busy5),  0);
        chk("full_valid", 32'(valid5), 0);
        repeat (2) tick();
        chk("done_hold_cnt", 32'(cnt5), 120);

        // Restart from DONE.
        q5.push_back('{ident(5), 1'b0});
        ready5 = 0; start5 = 1;
        tick();
        start5 = 0;
        chk("restart_cnt",   32'(cnt5),   0);
        chk("restart_valid", 32'(valid5), 1);
        chk("restart_done",  32'(done5),  0);
        chk("restart_busy",  32'(busy5),  1);
        tick();
        ready5 = 1;
        wait_hs(1, 121);
        tick();
        chk("restart_cnt1", 32'(cnt5), 1);
        ready5 = 0; abort5 = 1;
        tick();
        abort5 = 0;

        chk("q8_drained", 32'(q8.size()), 0);
        chk("q5_drained", 32'(q5.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jam_perm_sequencer.md
# jam_perm_sequencer

Controller that sequences the job-assignment cost datapath. It enumerates every assignment of N jobs to N workers, in strictly increasing lexicographic order, starting from the identity and ending at the fully descending permutation. Each permutation is offered to the downstream cost accumulator (the MinCost/MatchCount stage) over a valid/ready handshake. Permutation generation is separate from cost evaluation, so the accumulator can stall the search without losing state.

## Interface
Parameters:
- N, 8, number of workers and jobs.
- IDXW, 3, job index width; must equal clog2(N).
- CNTW, 16, width of perm_count; must hold N! (40320 for N=8).

Ports:
- CLK  in  1  clock. One clock domain; reset is synchronous and active-high.
- RST  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a full enumeration.
- abort  in  1  synchronous stop, accepted in any state.
- perm  out  N*IDXW  current permutation; bits [k*IDXW +: IDXW] hold the job assigned to worker k.
- perm_valid  out  1  perm is offered to downstream.
- perm_ready  in  1  downstream accepts perm.
- perm_last  out  1  qualifies perm_valid; the offered perm is the final, descending permutation.
- perm_count  out  CNTW  number of permutations accepted so far.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level signal; high in DONE.

## Operation
- States: IDLE, EMIT, PIVOT, SUCC, SWAP, REV, DONE.
- Reset values: state IDLE; perm = identity (worker k holds job k); perm_valid, perm_last, busy and done all 0; perm_count 0.
- IDLE, on start: load identity, clear perm_count, go to EMIT.
- EMIT:
  - perm_valid = 1.
  - perm_last = 1 when perm[k] = N-1-k for every k.
  - On perm_valid && perm_ready, perm_count increments by 1.
  - After an accepted handshake, go to DONE if perm_last was set, otherwise go to PIVOT with i = N-2.
- PIVOT: compare perm[i] with perm[i+1], one index per cycle.
  - If perm[i] < perm[i+1], latch i and go to SUCC with j = N-1.
  - Otherwise decrement i and stay in PIVOT.
  - A pivot always exists here, because the descending permutation is caught in EMIT.
- SUCC: one j per cycle.
  - If perm[j] > perm[i], latch j and go to SWAP.
  - Otherwise decrement j and stay in SUCC.
- SWAP: exchange perm[i] and perm[j]; go to REV.
- REV: reverse perm[i+1 .. N-1] in a single cycle; go to EMIT.
- DONE: done = 1 and perm_count is held. A start here restarts the enumeration exactly as from IDLE.
- start is ignored while busy.
- abort in any state: next cycle holds the reset values, state IDLE.
- If start and abort are asserted in the same cycle, abort wins.
- RST mid-operation behaves the same as abort.
- Arithmetic and widths:
  - Index comparisons are unsigned IDXW-bit.
  - i and j are IDXW-bit down-counters.
  - perm_count does not saturate. With CNTW=16 and N=8 it ends at 40320 and never wraps.

## Timing
- start accepted at edge t: perm_valid is high from cycle t+1, carrying the identity.
- Handshake to next perm_valid: (N-1-i) + (N-j) + 2 cycles, where i is the pivot and j the successor.
  - Minimum is 4 cycles (i = N-2, j = N-1).
  - Worst case is 2N cycles.
- While perm_valid && !perm_ready, perm and perm_last are held stable and perm_valid stays high.
- perm_valid is never dropped without a handshake, except on abort or RST.
- done rises in the cycle after the perm_last handshake is accepted.
- perm_count updates on the same edge as the handshake.
- All outputs are registered. perm_last is combinational from the perm register and is qualified by perm_valid.

## Structure
- Package jam_pkg holds:
  - the constants N, IDXW, CNTW;
  - the state enum for IDLE, EMIT, PIVOT, SUCC, SWAP, REV, DONE;
  - a perm_t type: an array of N IDXW-bit indices.
- Sub-module jam_suffix_reverse: combinational. Inputs are perm_t and pivot i; output is the permutation with the suffix after i reversed. It is instantiated once for REV.
- The FSM, the counters and the perm register stay in the top module.

## Test plan
- Reset, then idle for 5 cycles: perm = 0,1,2,3,4,5,6,7; perm_valid, perm_last, busy and done are 0; perm_count 0. A start asserted during RST has no effect.
- start with perm_ready tied high: first perm 0,1,2,3,4,5,6,7. Second perm 0,1,2,3,4,5,7,6 with perm_valid exactly 4 cycles after the first handshake. Third perm 0,1,2,3,4,6,5,7.
- Hold perm_ready low for 10 cycles on the third perm: perm and perm_valid are unchanged for all 10 cycles and perm_count stays at 2. Releasing perm_ready gives perm_count 3.
- Full run with random perm_ready:
  - exactly 40320 handshakes;
  - each perm strictly lexicographically greater than the previous one, with no repeats;
  - the final perm is 7,6,5,4,3,2,1,0 with perm_last = 1;
  - done = 1 the cycle after, with perm_count = 40320.
- abort after 100 handshakes while in SUCC: the next cycle holds the reset values in IDLE. A following start emits the identity again.
- start pulsed during PIVOT (ignored, sequence unaffected). start in DONE restarts, and perm_count returns to 0 then reaches 1 after the first handshake.
